// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one slow memory between an instruction-fetch
// port and a load/store port, holding each access for MEM_LATENCY cycles.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_done,
  output logic [31:0] i_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  // shared memory
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_last_d;
  logic        r_sel_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_gnt;
  logic        r_d_gnt;
  logic        r_i_done;
  logic        r_d_done;

  logic        w_win_d;
  logic        w_accept;
  logic        w_last_beat;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_busy;

  // On a tie the port that did not win last time goes first.
  assign w_win_d     = d_req && (!i_req || !r_last_d);
  assign w_accept    = (r_state == S_IDLE) && (i_req || d_req);
  assign w_last_beat = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_req || d_req) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        w_mem_read  = !r_we;
        // Single write strobe on the final beat gives exactly one write edge.
        w_mem_write = r_we && (r_cnt == 4'd0);
        if (r_cnt == 4'd0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_last_d  <= 1'b1;
      r_sel_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_i_rdata <= 32'd0;
      r_d_rdata <= 32'd0;
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_i_gnt  <= w_accept && !w_win_d;
      r_d_gnt  <= w_accept && w_win_d;
      r_i_done <= w_last_beat && !r_sel_d;
      r_d_done <= w_last_beat && r_sel_d;

      if (w_accept) begin
        r_last_d <= w_win_d;
        r_sel_d  <= w_win_d;
        r_we     <= w_win_d && d_we;
        r_addr   <= w_win_d ? d_addr : i_addr;
        r_cnt    <= CNT_INIT;
        if (w_win_d) begin
          r_wdata <= d_wdata;
        end
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_last_beat && !r_we) begin
        if (r_sel_d) begin
          r_d_rdata <= mem_dout;
        end else begin
          r_i_rdata <= mem_dout;
        end
      end
    end
  end

  assign i_gnt     = r_i_gnt;
  assign d_gnt     = r_d_gnt;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_addr;
  assign mem_din   = r_wdata;
  assign mem_read  = w_mem_read;
  assign mem_write = w_mem_write;
  assign busy      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (latency 4 and 1), each with its own
// memory, driven by directed and random traffic against a cycle-accurate model.
module tb_mem_port_arbiter;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic        i_gnt   [2];
  logic        i_done  [2];
  logic [31:0] i_rdata [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt   [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_din   [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_dout  [2];
  logic        busy      [2];

  bit [31:0] mem [2][256];

  // Reference model state.
  bit [31:0] ref_mem [2][256];
  bit [31:0] exp_i   [2];
  bit [31:0] exp_d   [2];
  bit        last_d  [2];

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_done(d_done[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_dout(mem_dout[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_done(d_done[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_dout(mem_dout[1]), .busy(busy[1])
  );

  assign mem_dout[0] = mem[0][mem_addr[0][9:2]];
  assign mem_dout[1] = mem[1][mem_addr[1][9:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_write[k]) mem[k][mem_addr[k][9:2]] <= mem_din[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic issue_i(input int k, input logic [31:0] a);
    i_req[k]  = 1'b1;
    i_addr[k] = a;
  endtask

  task automatic issue_d(input int k, input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_d[k] = 1'b1;
      exp_i[k]  = '0;
      exp_d[k]  = '0;
    end
  endtask

  task automatic check_reset(input int k);
    check($sformatf("rst_i_gnt%0d", k),  32'(i_gnt[k]), 32'd0);
    check($sformatf("rst_d_gnt%0d", k),  32'(d_gnt[k]), 32'd0);
    check($sformatf("rst_i_done%0d", k), 32'(i_done[k]), 32'd0);
    check($sformatf("rst_d_done%0d", k), 32'(d_done[k]), 32'd0);
    check($sformatf("rst_busy%0d", k),   32'(busy[k]), 32'd0);
    check($sformatf("rst_mem_read%0d", k),  32'(mem_read[k]), 32'd0);
    check($sformatf("rst_mem_write%0d", k), 32'(mem_write[k]), 32'd0);
    check($sformatf("rst_i_rdata%0d", k),  i_rdata[k], 32'd0);
    check($sformatf("rst_d_rdata%0d", k),  d_rdata[k], 32'd0);
    check($sformatf("rst_mem_addr%0d", k), mem_addr[k], 32'd0);
    check($sformatf("rst_mem_din%0d", k),  mem_din[k], 32'd0);
  endtask

  // Issues n_i fetches and n_d data accesses on instance k and checks every
  // cycle: each requester re-raises during DONE while it has work left, so
  // every later acceptance is a tie resolved by the alternation rule.
  // d_late holds back the first data request until the second BUSY cycle.
  task automatic run(input int k, input int n_i, input int n_d, input bit d_late,
                     input logic [31:0] ia, input logic [31:0] da,
                     input bit we, input logic [31:0] wd);
    int          lat;
    int          left_i;
    int          left_d;
    bit          pend_i;
    bit          pend_d;
    bit          cur_d;
    bit          op_we;
    logic [31:0] op_a;
    logic [31:0] op_wd;
    lat    = (k == 0) ? LAT0 : LAT1;
    left_i = n_i;
    left_d = n_d;
    pend_i = 1'b0;
    pend_d = 1'b0;
    @(negedge clk);
    if (left_i > 0) begin issue_i(k, ia); pend_i = 1'b1; left_i--; end
    if (left_d > 0 && !d_late) begin issue_d(k, we, da, wd); pend_d = 1'b1; left_d--; end
    while (pend_i || pend_d) begin
      cur_d     = pend_d && (!pend_i || !last_d[k]);
      last_d[k] = cur_d;
      op_we     = cur_d && d_we[k];
      op_a      = cur_d ? d_addr[k] : i_addr[k];
      op_wd     = d_wdata[k];
      @(negedge clk);
      check("i_gnt", 32'(i_gnt[k]), 32'(!cur_d));
      check("d_gnt", 32'(d_gnt[k]), 32'(cur_d));
      if (cur_d) begin d_req[k] = 1'b0; pend_d = 1'b0; end
      else       begin i_req[k] = 1'b0; pend_i = 1'b0; end
      for (int c = 0; c < lat; c++) begin
        if (c > 0) begin
          @(negedge clk);
          check("gnt_in_busy", 32'(i_gnt[k] | d_gnt[k]), 32'd0);
        end
        if (d_late && c == 1 && left_d > 0) begin
          issue_d(k, we, da, wd); pend_d = 1'b1; left_d--;
        end
        check("busy", 32'(busy[k]), 32'd1);
        check("mem_read", 32'(mem_read[k]), 32'(!op_we));
        check("mem_write", 32'(mem_write[k]), 32'(op_we && c == lat - 1));
        check("mem_addr", mem_addr[k], op_a);
        if (op_we) check("mem_din", mem_din[k], op_wd);
        check("done_early", 32'(i_done[k] | d_done[k]), 32'd0);
      end
      @(negedge clk);
      if (op_we)      ref_mem[k][op_a[9:2]] = op_wd;
      else if (cur_d) exp_d[k] = ref_mem[k][op_a[9:2]];
      else            exp_i[k] = ref_mem[k][op_a[9:2]];
      check("i_done", 32'(i_done[k]), 32'(!cur_d));
      check("d_done", 32'(d_done[k]), 32'(cur_d));
      check("gnt_in_done", 32'(i_gnt[k] | d_gnt[k]), 32'd0);
      check("rw_in_done", 32'(mem_read[k] | mem_write[k]), 32'd0);
      check("busy_done", 32'(busy[k]), 32'd1);
      check("i_rdata", i_rdata[k], exp_i[k]);
      check("d_rdata", d_rdata[k], exp_d[k]);
      if (op_we) check("mem_word", mem[k][op_a[9:2]], op_wd);
      if (left_i > 0 && !pend_i) begin issue_i(k, rand_addr()); pend_i = 1'b1; left_i--; end
      if (left_d > 0 && !pend_d) begin
        issue_d(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        pend_d = 1'b1; left_d--;
      end
      @(negedge clk);
      check("idle_busy", 32'(busy[k]), 32'd0);
      check("idle_pulses", 32'(i_gnt[k] | d_gnt[k] | i_done[k] | d_done[k]), 32'd0);
      check("idle_rw", 32'(mem_read[k] | mem_write[k]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    reset = 1'b0;

    // Ties straight after reset: fetch first, then strict alternation.
    run(0, 4, 4, 1'b0, rand_addr(), rand_addr(), 1'b1, $urandom);

    // Single fetch of a word written through the data port.
    run(0, 0, 1, 1'b0, '0, 32'h0000_000C, 1'b1, 32'hDEAD_BEEF);
    run(0, 1, 0, 1'b0, 32'h0000_000C, '0, 1'b0, '0);
    check("fetch_deadbeef", i_rdata[0], 32'hDEAD_BEEF);

    // Store then load.
    run(0, 0, 1, 1'b0, '0, 32'h0000_0040, 1'b1, 32'h1234_5678);
    run(0, 0, 1, 1'b0, '0, 32'h0000_0040, 1'b0, '0);
    check("load_12345678", d_rdata[0], 32'h1234_5678);

    // Data request raised while a fetch is in flight.
    run(0, 1, 1, 1'b1, 32'h0000_000C, 32'h0000_0040, 1'b0, '0);

    // Reset in the middle of a store.
    run(0, 0, 1, 1'b0, '0, 32'h0000_0080, 1'b1, 32'hAAAA_0000);
    @(negedge clk);
    issue_d(0, 1'b1, 32'h0000_0080, 32'h5555_1234);
    @(negedge clk);
    check("rst_store_gnt", 32'(d_gnt[0]), 32'd1);
    d_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_store_busy", 32'(busy[0]), 32'd1);
    check("rst_store_nowrite", 32'(mem_write[0]), 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_done", 32'(d_done[0] | busy[0]), 32'd0);
    end
    check("rst_mem_kept", mem[0][8'h20], 32'hAAAA_0000);
    check_reset(1);

    // Latency 1: fetch + store sequence, then contended traffic.
    run(1, 1, 1, 1'b0, rand_addr(), 32'h0000_0010, 1'b1, 32'hCAFE_F00D);
    run(1, 0, 1, 1'b0, '0, 32'h0000_0010, 1'b0, '0);
    check("lat1_load", d_rdata[1], 32'hCAFE_F00D);
    run(1, 3, 3, 1'b0, rand_addr(), rand_addr(), 1'b1, $urandom);

    // Random traffic on both instances.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 2; k++) begin
        run(k, $urandom_range(0, 2), $urandom_range(1, 2), 1'($urandom_range(0, 1)),
            rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
